// File: rtl/qsys_sequencer_cpu_jtag_host_driver_pkg.sv
// Shared definitions for the virtual-JTAG host driver and the debug-module side.
package qsys_sequencer_cpu_jtag_host_driver_pkg;

  localparam int JTAG_IR_W = 2;
  localparam int JTAG_DR_W = 38;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_UIR,
    ST_CDR,
    ST_SHIFT,
    ST_UDR,
    ST_RTI,
    ST_RESP
  } jtag_state_e;

endpackage

// File: rtl/qsys_sequencer_cpu_jtag_host_tckgen.sv
// tck divider: TCK_DIV clk cycles low then TCK_DIV high, held low while run is low.
module qsys_sequencer_cpu_jtag_host_tckgen
  import qsys_sequencer_cpu_jtag_host_driver_pkg::*;
#(
  parameter int TCK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tck,
  output logic rise_pulse,
  output logic period_end_pulse
);

  localparam int CW = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_half;
  logic          w_wrap;

  assign w_wrap = run && (r_cnt == CW'(TCK_DIV - 1));

  // Holding the counter at zero while idle makes every run start on a fresh low half.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (!run) begin
      r_cnt  <= '0;
      r_half <= 1'b0;
    end else if (w_wrap) begin
      r_cnt  <= '0;
      r_half <= ~r_half;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign tck              = r_half;
  assign rise_pulse       = w_wrap && !r_half;
  assign period_end_pulse = w_wrap && r_half;

endmodule

// File: rtl/qsys_sequencer_cpu_jtag_host_driver.sv
// Host-side virtual-JTAG initiator: one IR load plus one DR scan per command.
module qsys_sequencer_cpu_jtag_host_driver
  import qsys_sequencer_cpu_jtag_host_driver_pkg::*;
#(
  parameter int IR_W     = JTAG_IR_W,
  parameter int DR_W     = JTAG_DR_W,
  parameter int TCK_DIV  = 2,
  parameter int RTI_TCKS = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [IR_W-1:0] cmd_ir,
  input  logic [DR_W-1:0] cmd_dr,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DR_W-1:0] rsp_dr,
  output logic [IR_W-1:0] rsp_ir_out,
  output logic            vji_tck,
  output logic            vji_tdi,
  input  logic            vji_tdo,
  output logic [IR_W-1:0] vji_ir_in,
  input  logic [IR_W-1:0] vji_ir_out,
  output logic            vji_uir,
  output logic            vji_cdr,
  output logic            vji_sdr,
  output logic            vji_udr,
  output logic            vji_rti
);

  localparam int CNT_W = $clog2(DR_W + RTI_TCKS + 1);

  jtag_state_e     r_state;
  logic [DR_W-1:0] r_din;
  logic [DR_W-1:0] r_cap;
  logic [CNT_W-1:0] r_cnt;
  logic [IR_W-1:0] r_ir_in;
  logic [IR_W-1:0] r_ir_out;
  logic            r_cmd_ready, r_rsp_valid, r_tdi;
  logic            r_uir, r_cdr, r_sdr, r_udr, r_rti;
  logic            w_run, w_tck, w_rise, w_pend;

  assign w_run = (r_state != ST_IDLE) && (r_state != ST_RESP);

  qsys_sequencer_cpu_jtag_host_tckgen #(
    .TCK_DIV(TCK_DIV)
  ) u_tckgen (
    .clk             (clk),
    .reset_n         (reset_n),
    .run             (w_run),
    .tck             (w_tck),
    .rise_pulse      (w_rise),
    .period_end_pulse(w_pend)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_din       <= '0;
      r_cap       <= '0;
      r_cnt       <= '0;
      r_ir_in     <= '0;
      r_ir_out    <= '0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_tdi       <= 1'b0;
      r_uir       <= 1'b0;
      r_cdr       <= 1'b0;
      r_sdr       <= 1'b0;
      r_udr       <= 1'b0;
      r_rti       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_din       <= cmd_dr;
            r_ir_in     <= cmd_ir;
            r_uir       <= 1'b1;
            r_cmd_ready <= 1'b0;
            r_state     <= ST_UIR;
          end
        end
        ST_UIR: begin
          if (w_pend) begin
            r_uir   <= 1'b0;
            r_cdr   <= 1'b1;
            r_state <= ST_CDR;
          end
        end
        ST_CDR: begin
          // Bit 0 goes onto tdi together with the sdr strobe at the boundary.
          if (w_pend) begin
            r_cdr   <= 1'b0;
            r_sdr   <= 1'b1;
            r_tdi   <= r_din[0];
            r_din   <= r_din >> 1;
            r_cnt   <= '0;
            r_state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_rise) begin
            r_cap <= {vji_tdo, r_cap[DR_W-1:1]};
          end
          if (w_pend) begin
            if (r_cnt == CNT_W'(DR_W - 1)) begin
              r_sdr   <= 1'b0;
              r_udr   <= 1'b1;
              r_tdi   <= 1'b0;
              r_state <= ST_UDR;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
              r_tdi <= r_din[0];
              r_din <= r_din >> 1;
            end
          end
        end
        ST_UDR: begin
          if (w_pend) begin
            r_ir_out <= vji_ir_out;
            r_udr    <= 1'b0;
            r_rti    <= 1'b1;
            r_cnt    <= '0;
            r_state  <= ST_RTI;
          end
        end
        ST_RTI: begin
          if (w_pend) begin
            if (r_cnt == CNT_W'(RTI_TCKS - 1)) begin
              r_rti       <= 1'b0;
              r_rsp_valid <= 1'b1;
              r_state     <= ST_RESP;
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready  = r_cmd_ready;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_dr     = r_cap;
  assign rsp_ir_out = r_ir_out;
  assign vji_tck    = w_tck;
  assign vji_tdi    = r_tdi;
  assign vji_ir_in  = r_ir_in;
  assign vji_uir    = r_uir;
  assign vji_cdr    = r_cdr;
  assign vji_sdr    = r_sdr;
  assign vji_udr    = r_udr;
  assign vji_rti    = r_rti;

endmodule

// File: doc/qsys_sequencer_cpu_jtag_host_driver.md
Name: qsys_sequencer_cpu_jtag_host_driver

Overview:
Simulation and host-side initiator for the sequencer CPU's virtual-JTAG debug port. It drives the vji_* signal set that the debug module consumes: tck, tdi, ir_in, and the uir/cdr/sdr/udr/rti state strobes. It also captures vji_tdo and vji_ir_out. A command interface accepts one IR value plus one DR word, runs a complete UIR→CDR→SDR×DR_W→UDR→RTI sequence, and returns the captured DR word. Testbenches and the sim-only wrapper path use it in place of the hard JTAG hub.

Parameters:
IR_W, 2, virtual IR width
DR_W, 38, data-register scan length (matches jdo/sr width)
TCK_DIV, 2, clk cycles per tck half-period (>=1)
RTI_TCKS, 2, tck periods spent in run-test-idle after UDR (>=1)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  high only in IDLE
cmd_ir  in  IR_W  virtual IR value to load
cmd_dr  in  DR_W  DR word to shift in, LSB first
rsp_valid  out  1  result available; held until rsp_ready
rsp_ready  in  1  result accept
rsp_dr  out  DR_W  captured tdo word, first bit at bit 0
rsp_ir_out  out  IR_W  vji_ir_out sampled at end of UDR
vji_tck  out  1  generated tck
vji_tdi  out  1  serial data to target
vji_tdo  in  1  serial data from target
vji_ir_in  out  IR_W  virtual IR presented to target
vji_ir_out  in  IR_W  target IR status
vji_uir, vji_cdr, vji_sdr, vji_udr, vji_rti  out  1 each  virtual state strobes

Behaviour:
- Reset: all outputs 0, except cmd_ready=1. FSM=IDLE, tck low. An async reset mid-operation aborts the sequence, drops all strobes immediately and produces no response.
- tck period = 2*TCK_DIV clk cycles: TCK_DIV cycles low, then TCK_DIV cycles high. tck is stopped low in IDLE and RESP.
- Strobes, tdi and ir_in change only at a period boundary (tck falling edge). The target samples on the rising edge.
- vji_tdo is sampled on the clk cycle in which tck rises during SDR periods.
- FSM states: IDLE, UIR, CDR, SHIFT, UDR, RTI, RESP.
  - IDLE: on cmd_valid&&cmd_ready, latch cmd_ir/cmd_dr, reset the divider, enter UIR on the next clk.
  - UIR: 1 period, uir=1, ir_in=latched IR.
  - CDR: 1 period, cdr=1.
  - SHIFT: exactly DR_W periods, sdr=1. Bit i of cmd_dr is on tdi during period i. tdo is shifted into the capture register from the MSB end, right-shifting, so the bit sampled in period 0 lands in bit 0.
  - UDR: 1 period, udr=1. vji_ir_out is latched into rsp_ir_out at period end.
  - RTI: RTI_TCKS periods, rti=1.
  - RESP: rsp_valid=1, rsp_dr stable. On rsp_ready, go to IDLE and drop rsp_valid on the next clk.
- Exactly one strobe is high in UIR..RTI; none are high in IDLE/RESP.
- vji_ir_in holds its last loaded value after the sequence; it changes only in UIR.
- tdi returns to 0 outside SHIFT.
- Latency: rsp_valid rises exactly (DR_W+3+RTI_TCKS)*2*TCK_DIV clk cycles after the accept cycle. This is 172 at the defaults.
- cmd_valid while busy is ignored (no queueing). cmd_* only need to be stable in the accept cycle.
- Divider wrap: the counter runs 0..TCK_DIV-1. The half-period toggles on wrap. A period-end pulse coincides with the high→low transition.

Decomposition:
- Shared package: FSM state enum, default IR_W/DR_W constants shared with the debug-module side.
- One sub-module: qsys_sequencer_cpu_jtag_host_tckgen.
  - Inputs: clk, reset_n, run, TCK_DIV.
  - Outputs: tck, rise_pulse, period_end_pulse.
  - Counter restarts when run rises.

Test Plan:
- Reset → all strobes/tck/tdi/rsp_valid 0, cmd_ready 1, vji_ir_in 0.
- Loopback: tdo=tdi, TCK_DIV=2, cmd_ir=2'b01, cmd_dr=38'h2_AAAA_5555 →
  - rsp_dr=38'h2_AAAA_5555;
  - vji_sdr high for 38 tck periods = 152 clk;
  - rsp_valid at accept+172;
  - vji_ir_in=2'b01 from UIR onward.
- tdo tied 1, vji_ir_out=2'b10, cmd_dr=0 → rsp_dr=all ones, rsp_ir_out=2'b10, tdi stays 0 throughout.
- Back-pressure: rsp_ready low for 10 clk after rsp_valid → rsp_valid/rsp_dr held, cmd_ready 0. Second cmd_valid issued during SHIFT is ignored; no extra response.
- Reset pulse asserted mid-SHIFT (bit 17) → all outputs 0 within the same cycle. A new command afterward completes normally with correct loopback data.
- TCK_DIV=1, RTI_TCKS=1 → tck toggles every clk, latency (38+3+1)*2=84 clk, loopback data correct.
